// File: rtl/booth_r4_mul.sv
// Radix-4 (modified) Booth multiplier with its own IDLE/CALC/DONE sequencer.
// One Booth digit is retired per CALC cycle; the product register holds until the next done.
module booth_r4_mul #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            start,
  input  logic            signed_mode,
  input  logic [DW-1:0]   multiplicand,
  input  logic [DW-1:0]   multiplier,
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] product,
  output logic [1:0]      state_dbg
);

  localparam int N  = DW / 2 + 1;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW+1:0]   a_q, a_d;
  logic [DW+2:0]   acc_q, acc_d;
  logic [DW+1:0]   b_q, b_d;
  logic            bm1_q, bm1_d;
  logic [2*DW-1:0] product_q, product_d;

  logic [2:0]      triplet;
  logic [DW+2:0]   a_x;
  logic [DW+2:0]   addend;
  logic [DW+2:0]   sum;
  logic [DW+2:0]   acc_sh;
  logic [DW+1:0]   b_sh;
  logic [DW+1:0]   a_ext;
  logic [DW+1:0]   b_ext;

  // Datapath: recode, add into the upper half, then arithmetic shift right by two.
  always_comb begin
    triplet = {b_q[1:0], bm1_q};
    a_x     = {a_q[DW+1], a_q};
    case (triplet)
      3'b001, 3'b010: addend = a_x;
      3'b011:         addend = {a_q, 1'b0};
      3'b100:         addend = -{a_q, 1'b0};
      3'b101, 3'b110: addend = -a_x;
      default:        addend = '0;
    endcase
    sum    = acc_q + addend;
    acc_sh = {{2{sum[DW+2]}}, sum[DW+2:2]};
    b_sh   = {sum[1:0], b_q[DW+1:2]};
  end

  always_comb begin
    a_ext = signed_mode ? {{2{multiplicand[DW-1]}}, multiplicand} : {2'b00, multiplicand};
    b_ext = signed_mode ? {{2{multiplier[DW-1]}}, multiplier} : {2'b00, multiplier};
  end

  // clear outranks start; product is left untouched on abort.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    acc_d     = acc_q;
    b_d       = b_q;
    bm1_d     = bm1_q;
    product_d = product_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_CALC;
            cnt_d   = '0;
            a_d     = a_ext;
            acc_d   = '0;
            b_d     = b_ext;
            bm1_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CALC: begin
          acc_d = acc_sh;
          b_d   = b_sh;
          bm1_d = b_q[1];
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_d   = S_DONE;
            product_d = {acc_sh[DW-3:0], b_sh};
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      bm1_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      bm1_q     <= bm1_d;
      product_q <= product_d;
    end
  end

  assign busy      = (state_q == S_CALC);
  assign done      = (state_q == S_DONE);
  assign product   = product_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_booth_r4_mul.sv
// Self-checking bench for booth_r4_mul at DW=8: directed boundaries, abort/reset cases,
// back-to-back throughput and random operands checked against plain integer multiplication.
module tb_booth_r4_mul;

  localparam int DW = 8;
  localparam int N  = DW / 2 + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            clear;
  logic            start;
  logic            signed_mode;
  logic [DW-1:0]   multiplicand;
  logic [DW-1:0]   multiplier;
  logic            busy;
  logic            done;
  logic [2*DW-1:0] product;
  logic [1:0]      state_dbg;

  int total = 0;
  int bad   = 0;
  logic [2*DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  booth_r4_mul #(.DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .state_dbg    (state_dbg)
  );

  function automatic logic [2*DW-1:0] ref_mul(input logic sm, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    longint x, y, p;
    x = sm ? longint'($signed(a)) : longint'(a);
    y = sm ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[2*DW-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one operation from IDLE; start is re-raised mid-CALC with junk operands that must be ignored.
  task automatic run_op(input logic sm, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [2*DW-1:0] exp, input string tag);
    int cyc;
    int busy_cnt;
    signed_mode  = sm;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    tick();
    cyc      = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) busy_cnt++;
      start        = (cyc < 3);
      signed_mode  = 1'($urandom);
      multiplicand = DW'($urandom);
      multiplier   = DW'($urandom);
      tick();
      cyc++;
    end
    start = 1'b0;
    check({tag, " latency"}, cyc, N);
    check({tag, " busy_cycles"}, busy_cnt, N);
    check({tag, " product"}, product, exp);
    tick();
    check({tag, " done_pulse"}, done, 1'b0);
  endtask

  initial begin
    logic            sm;
    logic [DW-1:0]   a, b;
    logic [2*DW-1:0] prev;
    logic            seen;

    reset = 1'b0; clear = 1'b0; start = 1'b0;
    signed_mode = 1'b0; multiplicand = '0; multiplier = '0;
    #1;
    check("reset product", product, 0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    tick(); tick();
    reset = 1'b1;
    tick();

    run_op(1'b1, 8'hFD, 8'h07, 16'hFFEB, "s_m3x7");
    run_op(1'b1, 8'h80, 8'h80, 16'h4000, "s_min_x_min");
    run_op(1'b1, 8'h7F, 8'h80, 16'hC080, "s_max_x_min");
    run_op(1'b0, 8'hFF, 8'hFF, 16'hFE01, "u_max_x_max");
    run_op(1'b0, 8'h80, 8'h02, 16'h0100, "u_80x2");
    run_op(1'b1, 8'h00, 8'h9A, 16'h0000, "s_zero_a");
    run_op(1'b0, 8'hC3, 8'h00, 16'h0000, "u_zero_b");
    run_op(1'b1, 8'hFF, 8'hFF, 16'h0001, "s_m1xm1");
    run_op(1'b0, 8'hFD, 8'h07, 16'h06EB, "u_253x7");

    // Asynchronous reset two iterations into a calculation.
    signed_mode = 1'b1; multiplicand = 8'h55; multiplier = 8'h33; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    check("async_rst product", product, 0);
    check("async_rst busy", busy, 1'b0);
    check("async_rst done", done, 1'b0);
    tick();
    reset = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    check("async_rst no_done_after", seen, 1'b0);
    run_op(1'b1, 8'h55, 8'h33, ref_mul(1'b1, 8'h55, 8'h33), "after_rst");

    // start held high: accepts land every N+1 edges, operands in between are ignored.
    for (int e = 0; e < 5 * (N + 1); e++) begin
      sm = 1'($urandom); a = DW'($urandom); b = DW'($urandom);
      signed_mode = sm; multiplicand = a; multiplier = b; start = 1'b1;
      tick();
      if (e % (N + 1) == 0) exp_q.push_back(ref_mul(sm, a, b));
      check("b2b done_timing", done, (e % (N + 1) == N));
      if (done === 1'b1 && exp_q.size() > 0) check("b2b product", product, exp_q.pop_front());
    end
    start = 1'b0;
    check("b2b queue_drained", exp_q.size(), 0);
    tick(); tick();

    // clear on the third CALC cycle, with start on the same edge.
    prev = ref_mul(1'b0, 8'hA5, 8'h3C);
    run_op(1'b0, 8'hA5, 8'h3C, prev, "pre_clear");
    signed_mode = 1'b1; multiplicand = 8'h12; multiplier = 8'hE7; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    clear = 1'b1; start = 1'b1; multiplicand = 8'h6B; multiplier = 8'h91;
    tick();
    clear = 1'b0; start = 1'b0;
    check("clear busy", busy, 1'b0);
    check("clear done", done, 1'b0);
    check("clear product_held", product, prev);
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    check("clear no_done_after", seen, 1'b0);
    run_op(1'b1, 8'h6B, 8'h91, ref_mul(1'b1, 8'h6B, 8'h91), "after_clear");

    repeat (24) begin
      sm = 1'($urandom); a = DW'($urandom); b = DW'($urandom);
      run_op(sm, a, b, ref_mul(sm, a, b), sm ? "rand_s" : "rand_u");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
